// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads from the LSQ hit in the array or allocate an MSHR that requests the line over the
// tagged memory bus. Retired stores take bus priority and update a resident line. Load
// results leave in order through a small result queue to the CDB / PRF write port.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   lsq_rd_mem/addr/pr_idx/ar_idx      load request; Dcache_avail says it is taken
//   st_req/st_addr/st_value, st_ack    retired store; st_ack when memory accepts it
//   cdb_ready, cdb_*, prf_*            result queue head, popped on cdb_ready
//   proc2mem_*                         bus command (0 NONE, 1 LOAD, 2 STORE), addr, data
//   mem2proc_response/data/tag         bus grant tag, fill data and fill tag
module dcache_ctrl #(
    parameter int unsigned IDX_BITS = 5,
    parameter int unsigned NUM_MSHR = 4,
    parameter int unsigned RQ_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsq_rd_mem,
    input  logic [63:0] lsq_addr,
    input  logic [6:0]  lsq_pr_idx,
    input  logic [4:0]  lsq_ar_idx,
    output logic        Dcache_avail,
    input  logic        st_req,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_value,
    output logic        st_ack,
    input  logic        cdb_ready,
    output logic        cdb_complete,
    output logic [6:0]  cdb_pr_idx,
    output logic [4:0]  cdb_ar_idx,
    output logic        prf_wr_enable,
    output logic [63:0] prf_value,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag
);
    localparam int unsigned NLINES = 1 << IDX_BITS;
    localparam int unsigned TAG_W  = 64 - IDX_BITS - 3;
    localparam int unsigned BLK_W  = 61;
    localparam int unsigned MIDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
    localparam int unsigned PTR_W  = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RQ_DEPTH + NUM_MSHR + 1);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {M_FREE, M_ISSUE, M_WAIT} mshr_state_e;

    typedef struct packed {
        logic [BLK_W-1:0] blk;
        logic [6:0]       pr;
        logic [4:0]       ar;
        logic [3:0]       bus_tag;
        logic             no_alloc;
    } mshr_t;

    typedef struct packed {
        logic [6:0]  pr;
        logic [4:0]  ar;
        logic [63:0] data;
    } rq_entry_t;

    // Cache array
    logic              line_valid_q [NLINES];
    logic [TAG_W-1:0]  line_tag_q   [NLINES];
    logic [63:0]       line_data_q  [NLINES];

    // MSHRs
    mshr_state_e mshr_st_q [NUM_MSHR];
    mshr_state_e mshr_st_d [NUM_MSHR];
    mshr_t       mshr_q    [NUM_MSHR];
    mshr_t       mshr_d    [NUM_MSHR];

    // Result queue
    rq_entry_t        rq_mem_q [RQ_DEPTH];
    logic [PTR_W-1:0] rq_head_q, rq_head_d;
    logic [PTR_W-1:0] rq_tail_q, rq_tail_d;
    logic [CNT_W-1:0] rq_count_q, rq_count_d;

    logic [IDX_BITS-1:0] ld_idx, st_idx, fill_line_idx;
    logic [TAG_W-1:0]    ld_tag, st_tag, fill_line_tag;
    logic                ld_hit, st_hit, accept, acc_hit, acc_miss;
    logic                free_found, issue_found, fill_found;
    logic [MIDX_W-1:0]   free_idx, issue_idx, fill_idx;
    logic [CNT_W-1:0]    busy_cnt;
    logic                grant, ld_grant, fill_wr, rq_pop;
    logic                wr0_en, wr1_en;
    logic [PTR_W-1:0]    wr0_ptr, wr1_ptr;
    rq_entry_t           wr0_ent, wr1_ent;
    logic [1:0]          enq_n;
    logic                unused_bits;

    assign unused_bits = ^{lsq_addr[2:0], st_addr[2:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Tag lookups for the incoming load and store against the pre-edge array
    always_comb begin
        ld_idx = lsq_addr[IDX_BITS+2:3];
        ld_tag = lsq_addr[63:IDX_BITS+3];
        st_idx = st_addr[IDX_BITS+2:3];
        st_tag = st_addr[63:IDX_BITS+3];
        ld_hit = line_valid_q[ld_idx] && (line_tag_q[ld_idx] == ld_tag);
        st_hit = line_valid_q[st_idx] && (line_tag_q[st_idx] == st_tag);
    end

    // MSHR scan: lowest free, lowest ISSUE, busy count, and the WAIT entry matching a fill
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        fill_found  = 1'b0;
        fill_idx    = '0;
        busy_cnt    = '0;
        for (int i = int'(NUM_MSHR) - 1; i >= 0; i--) begin
            if (mshr_st_q[i] == M_FREE) begin
                free_found = 1'b1;
                free_idx   = MIDX_W'(i);
            end else begin
                busy_cnt = busy_cnt + CNT_W'(1);
            end
            if (mshr_st_q[i] == M_ISSUE) begin
                issue_found = 1'b1;
                issue_idx   = MIDX_W'(i);
            end
            if ((mem2proc_tag != 4'd0) && (mshr_st_q[i] == M_WAIT) &&
                (mshr_q[i].bus_tag == mem2proc_tag)) begin
                fill_found = 1'b1;
                fill_idx   = MIDX_W'(i);
            end
        end
    end

    // Every busy MSHR owns a reserved result slot, so a hit can never overflow the queue
    assign Dcache_avail = free_found && ((rq_count_q + busy_cnt) <= CNT_W'(RQ_DEPTH - 1));
    assign accept       = lsq_rd_mem && Dcache_avail;
    assign acc_hit      = accept && ld_hit;
    assign acc_miss     = accept && !ld_hit;

    // Bus request: store first, then lowest ISSUE MSHR
    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (st_req) begin
            proc2mem_command = CMD_STORE;
            proc2mem_addr    = {st_addr[63:3], 3'b000};
            proc2mem_data    = st_value;
        end else if (issue_found) begin
            proc2mem_command = CMD_LOAD;
            proc2mem_addr    = {mshr_q[issue_idx].blk, 3'b000};
        end
    end

    assign grant    = (mem2proc_response != 4'd0);
    assign st_ack   = st_req && grant;
    assign ld_grant = !st_req && issue_found && grant;

    // A store acked in the fill cycle to the same block makes the fill data stale
    always_comb begin
        fill_line_idx = mshr_q[fill_idx].blk[IDX_BITS-1:0];
        fill_line_tag = mshr_q[fill_idx].blk[BLK_W-1:IDX_BITS];
        fill_wr = fill_found && !mshr_q[fill_idx].no_alloc &&
                  !(st_ack && (st_addr[63:3] == mshr_q[fill_idx].blk));
    end

    // MSHR next state
    always_comb begin
        mshr_st_d = mshr_st_q;
        mshr_d    = mshr_q;
        for (int i = 0; i < int'(NUM_MSHR); i++) begin
            if (st_ack && (mshr_st_q[i] != M_FREE) && (mshr_q[i].blk == st_addr[63:3])) begin
                mshr_d[i].no_alloc = 1'b1;
            end
        end
        if (ld_grant) begin
            mshr_st_d[issue_idx]      = M_WAIT;
            mshr_d[issue_idx].bus_tag = mem2proc_response;
        end
        if (fill_found) begin
            mshr_st_d[fill_idx] = M_FREE;
        end
        if (acc_miss) begin
            mshr_st_d[free_idx]       = M_ISSUE;
            mshr_d[free_idx].blk      = lsq_addr[63:3];
            mshr_d[free_idx].pr       = lsq_pr_idx;
            mshr_d[free_idx].ar       = lsq_ar_idx;
            mshr_d[free_idx].bus_tag  = 4'd0;
            mshr_d[free_idx].no_alloc = 1'b0;
        end
    end

    // Result queue enqueue (fill ahead of hit) and pop
    always_comb begin
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;
        wr0_ptr    = rq_tail_q;
        wr1_ptr    = rq_tail_q;
        wr0_ent    = '0;
        wr1_ent    = '0;
        enq_n      = 2'd0;
        rq_tail_d  = rq_tail_q;
        if (fill_found) begin
            wr0_en    = 1'b1;
            wr0_ptr   = rq_tail_d;
            wr0_ent   = '{pr: mshr_q[fill_idx].pr, ar: mshr_q[fill_idx].ar, data: mem2proc_data};
            rq_tail_d = ptr_inc(rq_tail_d);
            enq_n     = enq_n + 2'd1;
        end
        if (acc_hit) begin
            wr1_en    = 1'b1;
            wr1_ptr   = rq_tail_d;
            wr1_ent   = '{pr: lsq_pr_idx, ar: lsq_ar_idx, data: line_data_q[ld_idx]};
            rq_tail_d = ptr_inc(rq_tail_d);
            enq_n     = enq_n + 2'd1;
        end
        rq_pop     = cdb_complete && cdb_ready;
        rq_head_d  = rq_pop ? ptr_inc(rq_head_q) : rq_head_q;
        rq_count_d = rq_count_q + CNT_W'(enq_n) - CNT_W'(rq_pop);
    end

    assign cdb_complete  = (rq_count_q != '0);
    assign prf_wr_enable = cdb_complete;
    assign cdb_pr_idx    = cdb_complete ? rq_mem_q[rq_head_q].pr   : 7'd0;
    assign cdb_ar_idx    = cdb_complete ? rq_mem_q[rq_head_q].ar   : 5'd0;
    assign prf_value     = cdb_complete ? rq_mem_q[rq_head_q].data : 64'd0;

    // Control state with reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_MSHR); i++) begin
                mshr_st_q[i] <= M_FREE;
            end
            for (int i = 0; i < int'(NLINES); i++) begin
                line_valid_q[i] <= 1'b0;
            end
            rq_head_q  <= '0;
            rq_tail_q  <= '0;
            rq_count_q <= '0;
        end else begin
            mshr_st_q  <= mshr_st_d;
            if (fill_wr) begin
                line_valid_q[fill_line_idx] <= 1'b1;
            end
            rq_head_q  <= rq_head_d;
            rq_tail_q  <= rq_tail_d;
            rq_count_q <= rq_count_d;
        end
    end

    // Payload storage; meaningful only under the valid/state bits above
    always_ff @(posedge clock) begin
        mshr_q <= mshr_d;
        if (wr0_en) begin
            rq_mem_q[wr0_ptr] <= wr0_ent;
        end
        if (wr1_en) begin
            rq_mem_q[wr1_ptr] <= wr1_ent;
        end
        // Store update first so a same-cycle fill into that index replaces it
        if (st_ack && st_hit) begin
            line_data_q[st_idx] <= st_value;
        end
        if (fill_wr) begin
            line_data_q[fill_line_idx] <= mem2proc_data;
            line_tag_q[fill_line_idx]  <= fill_line_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: cold miss, refusal retry, store priority,
// store during miss, saturation/backpressure and reset while a miss is outstanding.
module tb_dcache_ctrl;
    logic        clock;
    logic        reset;
    logic        lsq_rd_mem;
    logic [63:0] lsq_addr;
    logic [6:0]  lsq_pr_idx;
    logic [4:0]  lsq_ar_idx;
    logic        Dcache_avail;
    logic        st_req;
    logic [63:0] st_addr;
    logic [63:0] st_value;
    logic        st_ack;
    logic        cdb_ready;
    logic        cdb_complete;
    logic [6:0]  cdb_pr_idx;
    logic [4:0]  cdb_ar_idx;
    logic        prf_wr_enable;
    logic [63:0] prf_value;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .lsq_rd_mem        (lsq_rd_mem),
        .lsq_addr          (lsq_addr),
        .lsq_pr_idx        (lsq_pr_idx),
        .lsq_ar_idx        (lsq_ar_idx),
        .Dcache_avail      (Dcache_avail),
        .st_req            (st_req),
        .st_addr           (st_addr),
        .st_value          (st_value),
        .st_ack            (st_ack),
        .cdb_ready         (cdb_ready),
        .cdb_complete      (cdb_complete),
        .cdb_pr_idx        (cdb_pr_idx),
        .cdb_ar_idx        (cdb_ar_idx),
        .prf_wr_enable     (prf_wr_enable),
        .prf_value         (prf_value),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        lsq_rd_mem        = 1'b0;
        lsq_addr          = '0;
        lsq_pr_idx        = '0;
        lsq_ar_idx        = '0;
        st_req            = 1'b0;
        st_addr           = '0;
        st_value          = '0;
        cdb_ready         = 1'b0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
    endtask

    task automatic drive_load(input logic [63:0] a, input logic [6:0] pr, input logic [4:0] ar);
        lsq_rd_mem = 1'b1;
        lsq_addr   = a;
        lsq_pr_idx = pr;
        lsq_ar_idx = ar;
    endtask

    task automatic check_result(input string tag, input logic [6:0] pr, input logic [4:0] ar,
                                input logic [63:0] val);
        check_eq({tag, "_complete"}, 64'(cdb_complete), 64'd1);
        check_eq({tag, "_pr"},       64'(cdb_pr_idx),   64'(pr));
        check_eq({tag, "_ar"},       64'(cdb_ar_idx),   64'(ar));
        check_eq({tag, "_value"},    prf_value,         val);
    endtask

    // Pop the queue head for one cycle
    task automatic pop_one();
        cdb_ready = 1'b1;
        step();
        cdb_ready = 1'b0;
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_avail",    64'(Dcache_avail),     64'd1);
        check_eq("rst_complete", 64'(cdb_complete),     64'd0);
        check_eq("rst_prf_we",   64'(prf_wr_enable),    64'd0);
        check_eq("rst_pr",       64'(cdb_pr_idx),       64'd0);
        check_eq("rst_ar",       64'(cdb_ar_idx),       64'd0);
        check_eq("rst_value",    prf_value,             64'd0);
        check_eq("rst_cmd",      64'(proc2mem_command), 64'd0);
        check_eq("rst_addr",     proc2mem_addr,         64'd0);
        check_eq("rst_data",     proc2mem_data,         64'd0);
        check_eq("rst_st_ack",   64'(st_ack),           64'd0);

        // 1: cold miss, fill after 10 cycles, then reload hits
        drive_load(64'h1000, 7'd12, 5'd3);
        #1;
        check_eq("t1_avail", 64'(Dcache_avail), 64'd1);
        step();
        clear_in();
        #1;
        check_eq("t1_cmd_load", 64'(proc2mem_command), 64'd1);
        check_eq("t1_addr",     proc2mem_addr,         64'h1000);
        mem2proc_response = 4'd5;
        step();
        mem2proc_response = 4'd0;
        #1;
        check_eq("t1_cmd_none", 64'(proc2mem_command), 64'd0);
        repeat (9) step();
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'hDEAD;
        #1;
        check_eq("t1_not_yet", 64'(cdb_complete), 64'd0);
        step();
        clear_in();
        #1;
        check_result("t1_fill", 7'd12, 5'd3, 64'hDEAD);
        check_eq("t1_prf_we", 64'(prf_wr_enable), 64'd1);
        pop_one();
        check_eq("t1_popped", 64'(cdb_complete), 64'd0);
        drive_load(64'h1000, 7'd13, 5'd4);
        step();
        clear_in();
        #1;
        check_result("t1_hit", 7'd13, 5'd4, 64'hDEAD);
        check_eq("t1_hit_nobus", 64'(proc2mem_command), 64'd0);
        pop_one();

        // 3: store wins the bus over an ISSUE MSHR, then the load goes out
        drive_load(64'h4008, 7'd30, 5'd6);
        step();
        clear_in();
        st_req            = 1'b1;
        st_addr           = 64'h1000;
        st_value          = 64'h55;
        mem2proc_response = 4'd15;
        #1;
        check_eq("t3_cmd_store", 64'(proc2mem_command), 64'd2);
        check_eq("t3_st_addr",   proc2mem_addr,         64'h1000);
        check_eq("t3_st_data",   proc2mem_data,         64'h55);
        check_eq("t3_st_ack",    64'(st_ack),           64'd1);
        step();
        clear_in();
        #1;
        check_eq("t3_cmd_load",  64'(proc2mem_command), 64'd1);
        check_eq("t3_ld_addr",   proc2mem_addr,         64'h4008);
        check_eq("t3_no_ack",    64'(st_ack),           64'd0);
        mem2proc_response = 4'd6;
        step();
        clear_in();
        mem2proc_tag  = 4'd6;
        mem2proc_data = 64'h4444;
        step();
        clear_in();
        #1;
        check_result("t3_fill", 7'd30, 5'd6, 64'h4444);
        pop_one();
        drive_load(64'h1000, 7'd14, 5'd7);
        step();
        clear_in();
        #1;
        check_result("t3_hit_store", 7'd14, 5'd7, 64'h55);
        pop_one();

        // 2: refused LOAD repeats unchanged until granted
        drive_load(64'h2000, 7'd20, 5'd8);
        step();
        clear_in();
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("t2_retry_cmd",  64'(proc2mem_command), 64'd1);
            check_eq("t2_retry_addr", proc2mem_addr,         64'h2000);
            step();
        end
        mem2proc_response = 4'd2;
        #1;
        check_eq("t2_grant_cmd", 64'(proc2mem_command), 64'd1);
        step();
        clear_in();
        #1;
        check_eq("t2_after_grant", 64'(proc2mem_command), 64'd0);
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'h2222;
        step();
        clear_in();
        #1;
        check_result("t2_fill", 7'd20, 5'd8, 64'h2222);
        pop_one();

        // 4: store to the block of a WAIT miss suppresses allocation of the fill
        drive_load(64'h3000, 7'd21, 5'd9);
        step();
        clear_in();
        mem2proc_response = 4'd7;
        step();
        clear_in();
        st_req            = 1'b1;
        st_addr           = 64'h3000;
        st_value          = 64'h99;
        mem2proc_response = 4'd15;
        #1;
        check_eq("t4_st_ack", 64'(st_ack), 64'd1);
        step();
        clear_in();
        mem2proc_tag  = 4'd7;
        mem2proc_data = 64'h77;
        step();
        clear_in();
        #1;
        check_result("t4_fill", 7'd21, 5'd9, 64'h77);
        pop_one();
        drive_load(64'h3000, 7'd22, 5'd10);
        step();
        clear_in();
        #1;
        check_eq("t4_reload_miss", 64'(cdb_complete),     64'd0);
        check_eq("t4_reload_cmd",  64'(proc2mem_command), 64'd1);
        check_eq("t4_reload_addr", proc2mem_addr,         64'h3000);
        mem2proc_response = 4'd8;
        step();
        clear_in();
        mem2proc_tag  = 4'd8;
        mem2proc_data = 64'h99;
        step();
        clear_in();
        #1;
        check_result("t4_refill", 7'd22, 5'd10, 64'h99);
        pop_one();

        // 5: four outstanding misses saturate; fills return out of order with backpressure
        for (int k = 0; k < 4; k++) begin
            drive_load(64'h5000 + 64'(k * 8), 7'(40 + k), 5'(1 + k));
            #1;
            check_eq("t5_avail_pre", 64'(Dcache_avail), 64'd1);
            step();
        end
        drive_load(64'h6000, 7'd50, 5'd20);
        #1;
        check_eq("t5_avail_full", 64'(Dcache_avail), 64'd0);
        step();
        clear_in();
        #1;
        check_eq("t5_head_addr", proc2mem_addr, 64'h5000);
        for (int k = 0; k < 4; k++) begin
            mem2proc_response = 4'(k + 1);
            #1;
            check_eq("t5_issue_addr", proc2mem_addr, 64'h5000 + 64'(k * 8));
            step();
        end
        clear_in();
        #1;
        check_eq("t5_bus_idle", 64'(proc2mem_command), 64'd0);
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'h33;
        step();
        mem2proc_tag  = 4'd1;
        mem2proc_data = 64'h11;
        step();
        clear_in();
        #1;
        check_result("t5_first", 7'd42, 5'd3, 64'h33);
        check_eq("t5_avail_reserved", 64'(Dcache_avail), 64'd0);
        step();
        check_result("t5_held", 7'd42, 5'd3, 64'h33);
        cdb_ready = 1'b1;
        step();
        check_result("t5_second", 7'd40, 5'd1, 64'h11);
        step();
        cdb_ready = 1'b0;
        #1;
        check_eq("t5_drained",     64'(cdb_complete), 64'd0);
        check_eq("t5_avail_again", 64'(Dcache_avail), 64'd1);

        // 6: reset with misses in WAIT; stale fill ignored and array invalidated
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'hBAD;
        #1;
        check_eq("t6_avail", 64'(Dcache_avail), 64'd1);
        step();
        clear_in();
        #1;
        check_eq("t6_stale_fill", 64'(cdb_complete), 64'd0);
        drive_load(64'h5010, 7'd60, 5'd11);
        step();
        clear_in();
        #1;
        check_eq("t6_invalid_miss", 64'(cdb_complete),     64'd0);
        check_eq("t6_miss_cmd",     64'(proc2mem_command), 64'd1);
        check_eq("t6_miss_addr",    proc2mem_addr,         64'h5010);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
